// File: rtl/iir_sequencer.sv
// iir_sequencer: drives a shared MAC through the NB+NA terms of a direct-form-I IIR section per sample,
// owning the coefficient file and x/y history, and rescales/saturates the accumulator into y_out.
module iir_sequencer #(
  parameter int opsize = 8,
  parameter int NB = 3,
  parameter int NA = 2,
  parameter int FRAC = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [opsize-1:0]   x_in,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NB+NA)-1:0]   coef_addr,
  input  logic signed [opsize-1:0]   coef_data,
  output logic signed [opsize-1:0]   y_out,
  output logic                       y_valid,
  output logic                       busy,
  output logic                       mac_clr,
  output logic                       mac_start,
  output logic signed [opsize-1:0]   mac_a,
  output logic signed [opsize-1:0]   mac_b,
  input  logic                       mac_ready,
  input  logic signed [2*opsize-1:0] mac_acc
);
  localparam int NT = NB + NA;
  localparam int AW = $clog2(NT);
  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] k;
  logic signed [opsize-1:0] coef [NT];
  // x[n], x[n-1] .. x[n-NB+1], then y[n-1] .. y[n-NA]: term k reads hist[k] against coef[k]
  logic signed [opsize-1:0] hist [NT];
  logic signed [opsize-1:0] y_q, y_sat;
  logic signed [2*opsize-1:0] t;
  logic last, hi_ok, opnd;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      k <= '0;
      y_q <= '0;
      for (int i = 0; i < NT; i++) begin
        coef[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == IDLE && coef_we && int'(coef_addr) < NT) coef[coef_addr] <= coef_data;
      if (state == IDLE && x_valid) hist[0] <= x_in;
      if (state == CLEAR) k <= '0;
      else if (state == WAIT_HI && mac_ready && !last) k <= k + 1'b1;
      if (state == DONE) begin
        y_q <= y_sat;
        for (int i = 1; i < NB; i++) hist[i] <= hist[i-1];
        hist[NB] <= y_sat;
        for (int i = NB + 1; i < NT; i++) hist[i] <= hist[i-1];
      end
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = x_valid ? CLEAR : IDLE;
      CLEAR:   state_nx = ISSUE;
      ISSUE:   state_nx = WAIT_LO;
      WAIT_LO: state_nx = mac_ready ? WAIT_LO : WAIT_HI;
      WAIT_HI: state_nx = !mac_ready ? WAIT_HI : last ? DONE : ISSUE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign last = k == AW'(NT - 1);
  assign t = mac_acc >>> FRAC;
  // in range when every bit above the output sign bit matches it
  assign hi_ok = &t[2*opsize-1:opsize-1] | ~|t[2*opsize-1:opsize-1];
  assign y_sat = hi_ok ? t[opsize-1:0] : {t[2*opsize-1], {(opsize-1){~t[2*opsize-1]}}};
  assign opnd = state inside {ISSUE, WAIT_LO, WAIT_HI};
  assign x_ready = state == IDLE;
  assign busy = !x_ready;
  assign mac_clr = state == CLEAR;
  assign mac_start = state == ISSUE;
  assign y_valid = state == DONE;
  assign y_out = y_valid ? y_sat : y_q;
  assign mac_a = opnd ? hist[k] : '0;
  assign mac_b = opnd ? coef[k] : '0;
endmodule

// File: tb/tb_iir_sequencer.sv
// tb_iir_sequencer: directed and randomized checks of iir_sequencer against a MAC model and an arithmetic reference.
module tb_iir_sequencer;
  localparam int NB = 3;
  localparam int NA = 2;
  localparam int NT = NB + NA;
  localparam int FRAC = 6;
  logic clk = 1'b0;
  logic reset;
  logic signed [7:0] x_in;
  logic x_valid, x_ready, coef_we;
  logic [2:0] coef_addr;
  logic signed [7:0] coef_data, y_out, mac_a, mac_b;
  logic y_valid, busy, mac_clr, mac_start;
  logic mac_ready = 1'b1;
  logic signed [15:0] acc = '0;
  logic signed [15:0] prod = '0;
  logic pend = 1'b0;
  int mcnt = 0;
  int mlat = 3;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t0 = 0;
  int clr_cnt = 0;
  int acc_cnt = 0;
  typedef struct {int y; int due;} exp_t;
  exp_t q[$];
  int mcoef [NT];
  int mx [NB];
  int my [NA];
  iir_sequencer #(.opsize(8), .NB(NB), .NA(NA), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y_out), .y_valid(y_valid), .busy(busy), .mac_clr(mac_clr), .mac_start(mac_start),
    .mac_a(mac_a), .mac_b(mac_b), .mac_ready(mac_ready), .mac_acc(acc)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // MAC: ready low for mlat cycles after a start, accumulator updates one cycle after ready rises
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (pend) acc <= acc + prod;
    pend <= 1'b0;
    if (mac_start && mac_ready) begin
      prod <= mac_a * mac_b;
      mac_ready <= 1'b0;
      mcnt <= mlat;
    end else if (!mac_ready) begin
      if (mcnt <= 1) begin
        mac_ready <= 1'b1;
        pend <= 1'b1;
      end else mcnt <= mcnt - 1;
    end
  end
  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // Reference: y[n] = sat((sum b_k x[n-k] + sum (-a_j) y[n-j]) wrapped to 16 bits >>> FRAC)
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      for (int i = 0; i < NT; i++) mcoef[i] = 0;
      for (int i = 0; i < NB; i++) mx[i] = 0;
      for (int i = 0; i < NA; i++) my[i] = 0;
      chk("reset_y_valid", y_valid, 0);
      chk("reset_busy", busy, 0);
    end else begin
      chk("x_ready_vs_busy", x_ready, !busy);
      if (mac_start) chk("start_while_mac_busy", mac_ready, 1);
      if (mac_clr) clr_cnt++;
      if (y_valid) begin
        if (q.size() == 0) chk("unexpected_y_valid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("y_out", y_out, e.y);
          chk("y_timing", cyc, e.due);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        chk("y_missing", 0, 1);
        void'(q.pop_front());
      end
      if (x_ready) begin
        if (coef_we && int'(coef_addr) < NT) mcoef[int'(coef_addr)] = int'(coef_data);
        if (x_valid) begin
          int s, t, y;
          logic signed [15:0] a16;
          for (int i = NB - 1; i > 0; i--) mx[i] = mx[i-1];
          mx[0] = int'(x_in);
          s = 0;
          for (int i = 0; i < NB; i++) s += mcoef[i] * mx[i];
          for (int j = 0; j < NA; j++) s += mcoef[NB+j] * my[j];
          a16 = 16'(s);
          t = int'(a16 >>> FRAC);
          y = t > 127 ? 127 : t < -128 ? -128 : t;
          for (int j = NA - 1; j > 0; j--) my[j] = my[j-1];
          my[0] = y;
          q.push_back('{y: y, due: cyc + 2 + NT * (mlat + 2)});
          acc_cnt++;
        end
      end
    end
  end
  task automatic wr(input int addr, input int data);
    coef_we = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 8'(data);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask
  task automatic send_x(input int xv);
    x_in = 8'(xv);
    x_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask
  task automatic wait_y(input bit chk_y, input int exp_y, input bit chk_lat, input int exp_lat);
    int n = 0;
    while (!y_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!y_valid) chk("y_timeout", 0, 1);
    else begin
      if (chk_y) chk("y_literal", y_out, exp_y);
      if (chk_lat) chk("latency_literal", cyc - t0, exp_lat);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    int prev, n;
    reset = 1'b0;
    x_valid = 1'b0;
    coef_we = 1'b0;
    x_in = '0;
    coef_addr = '0;
    coef_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x_ready", x_ready, 1);
    chk("rst_y_out", y_out, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_mac_start", mac_start, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    // identity
    mlat = 3;
    wr(0, 64);
    send_x(48);   wait_y(1, 48, 1, 27);
    send_x(-48);  wait_y(1, -48, 1, 27);
    send_x(127);  wait_y(1, 127, 1, 27);
    // flush y history, then feedback decay
    send_x(0); wait_y(1, 0, 0, 0);
    send_x(0); wait_y(1, 0, 0, 0);
    wr(3, 32);
    send_x(64); wait_y(1, 64, 0, 0);
    send_x(0);  wait_y(1, 32, 0, 0);
    send_x(0);  wait_y(1, 16, 0, 0);
    send_x(0);  wait_y(1, 8, 0, 0);
    // saturation
    wr(3, 0);
    wr(0, 127);
    send_x(127);  wait_y(1, 127, 0, 0);
    send_x(-128); wait_y(1, -128, 0, 0);
    // write lockout while busy
    wr(0, 64);
    send_x(20);
    repeat (4) @(posedge clk);
    #1;
    chk("lockout_busy", busy, 1);
    wr(0, 0);
    wait_y(1, 20, 0, 0);
    send_x(30); wait_y(1, 30, 0, 0);
    wr(0, 0);
    send_x(30); wait_y(1, 0, 0, 0);
    // randomized coefficients, samples, MAC latency and concurrent/locked-out writes
    for (int s = 0; s < 40; s++) begin
      mlat = $urandom_range(1, 4);
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, 7), $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        coef_we = 1'b1;
        coef_addr = 3'($urandom_range(0, 7));
        coef_data = 8'($urandom_range(0, 255));
      end
      send_x($urandom_range(0, 255));
      coef_we = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        repeat (3) @(posedge clk);
        #1;
        wr($urandom_range(0, 7), $urandom_range(0, 255));
      end
      wait_y(0, 0, 0, 0);
    end
    // reset during the third term's WAIT_HI
    mlat = 3;
    wr(0, 64); wr(1, 20); wr(3, 40);
    send_x(100); wait_y(0, 0, 0, 0);
    send_x(-70); wait_y(0, 0, 0, 0);
    send_x(90);
    repeat (14) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_mac_ready", mac_ready, 0);
    reset = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_y_valid", y_valid, 0);
    chk("async_x_ready", x_ready, 1);
    chk("async_mac_start", mac_start, 0);
    chk("async_mac_clr", mac_clr, 0);
    chk("async_y_out", y_out, 0);
    chk("async_mac_a", mac_a, 0);
    chk("async_mac_b", mac_b, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    wr(0, 64);
    send_x(10); wait_y(1, 10, 1, 27);
    // x_valid held high: one acceptance per x_ready cycle, fixed spacing
    mlat = 2;
    wr(1, 16); wr(4, 8);
    x_valid = 1'b1;
    prev = 0;
    for (int s = 0; s < 6; s++) begin
      n = 0;
      while (!x_ready && n < 100) begin
        x_in = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        n++;
      end
      if (!x_ready) chk("handshake_timeout", 0, 1);
      else if (s > 0) chk("handshake_spacing", cyc - prev, 3 + NT * (mlat + 2));
      prev = cyc;
      x_in = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size(), 0);
    chk("clr_per_sample", clr_cnt, acc_cnt);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
